// File: rtl/read_level_detector_if.sv
// Bus bundle for read_level_detector.
//  slave  : the detector (consumes levels/voltages/start, drives results)
//  master : the environment feeding the detector
// Inputs to the detector:
//  levelValid/levelIn     written-level push into the FIFO
//  voltageValid/voltageIn distorted Vth to slice (pops the FIFO head)
//  start                  begin a new measurement frame
// Outputs from the detector:
//  detectValid/detectLevel/symbolError  per-symbol result
//  busy/done                            frame FSM status
//  symbolCount/symbolErrCount/bitErrCount frame counters
//  fifoOverflow/fifoUnderflow           sticky FIFO error flags
interface read_level_detector_if;
  logic        levelValid;
  logic [1:0]  levelIn;
  logic        voltageValid;
  logic [15:0] voltageIn;
  logic        start;
  logic        detectValid;
  logic [1:0]  detectLevel;
  logic        symbolError;
  logic        busy;
  logic        done;
  logic [31:0] symbolCount;
  logic [31:0] symbolErrCount;
  logic [31:0] bitErrCount;
  logic        fifoOverflow;
  logic        fifoUnderflow;

  modport slave (
    input  levelValid, levelIn, voltageValid, voltageIn, start,
    output detectValid, detectLevel, symbolError, busy, done,
           symbolCount, symbolErrCount, bitErrCount,
           fifoOverflow, fifoUnderflow
  );

  modport master (
    output levelValid, levelIn, voltageValid, voltageIn, start,
    input  detectValid, detectLevel, symbolError, busy, done,
           symbolCount, symbolErrCount, bitErrCount,
           fifoOverflow, fifoUnderflow
  );
endinterface

// File: rtl/read_level_detector.sv
// read_level_detector
//  Hard-decision read stage: slices a 16-bit distorted threshold voltage into
//  a 2-bit MLC level with three read references, compares it to the written
//  level queued in a FIFO at program time, and accumulates per-frame symbol,
//  symbol-error and Gray-coded bit-error counts.
// Ports:
//  clk    system clock
//  reset  synchronous, active-high reset
//  bus    read_level_detector_if.slave (see interface file for signal list)
module read_level_detector #(
  parameter logic [15:0] VREF1      = 16'd2048,
  parameter logic [15:0] VREF2      = 16'd4096,
  parameter logic [15:0] VREF3      = 16'd6144,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] FRAME_LEN  = 32'd1024
) (
  input logic                   clk,
  input logic                   reset,
  read_level_detector_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Gray map chosen so adjacent levels differ by one bit.
  function automatic logic [1:0] gray(input logic [1:0] lvl);
    case (lvl)
      2'd0:    gray = 2'b11;
      2'd1:    gray = 2'b10;
      2'd2:    gray = 2'b00;
      default: gray = 2'b01;
    endcase
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, b};
    sat_add = s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // ---------------- state ----------------
  logic [FIFO_DEPTH-1:0][1:0] fifo_mem_q, fifo_mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [AW:0]                fifo_cnt_q, fifo_cnt_d;

  logic [1:0]  state_q, state_d;
  logic        det_valid_q, det_valid_d;
  logic [1:0]  det_level_q, det_level_d;
  logic        sym_err_q, sym_err_d;
  logic        done_q, done_d;
  logic [31:0] sym_cnt_q, sym_cnt_d;
  logic [31:0] sym_err_cnt_q, sym_err_cnt_d;
  logic [31:0] bit_err_cnt_q, bit_err_cnt_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  // ---------------- datapath ----------------
  logic       fifo_empty, fifo_full;
  logic       do_pop, do_push, ovf_evt, udf_evt, start_acc;
  logic [1:0] head_lvl, slice_lvl, gray_x, bit_err;
  logic       mismatch;

  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == DEPTH_C);
    // Pop only real data; an empty pop never bypasses a same-cycle push.
    do_pop     = bus.voltageValid && !fifo_empty;
    // A simultaneous pop frees a slot, so push succeeds even when full.
    do_push    = bus.levelValid && (!fifo_full || do_pop);
    ovf_evt    = bus.levelValid && fifo_full && !do_pop;
    udf_evt    = bus.voltageValid && fifo_empty;
    head_lvl   = fifo_mem_q[rd_ptr_q];

    // Equality with a reference resolves to the upper level.
    if (bus.voltageIn < VREF1)      slice_lvl = 2'd0;
    else if (bus.voltageIn < VREF2) slice_lvl = 2'd1;
    else if (bus.voltageIn < VREF3) slice_lvl = 2'd2;
    else                            slice_lvl = 2'd3;

    mismatch = do_pop && (slice_lvl != head_lvl);
    gray_x   = do_pop ? (gray(head_lvl) ^ gray(slice_lvl)) : 2'b00;
    bit_err  = {1'b0, gray_x[1]} + {1'b0, gray_x[0]};
  end

  // ---------------- FIFO next state ----------------
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (do_push) begin
      fifo_mem_d[wr_ptr_q] = bus.levelIn;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------- detection + FSM/counters ----------------
  always_comb begin
    det_valid_d   = bus.voltageValid;
    det_level_d   = bus.voltageValid ? slice_lvl : det_level_q;
    sym_err_d     = mismatch;
    done_d        = 1'b0;
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    sym_err_cnt_d = sym_err_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;
    ovf_d         = ovf_q;
    udf_d         = udf_q;

    // start is only honoured outside RUN.
    start_acc = bus.start && (state_q != S_RUN);

    if (start_acc) begin
      state_d       = S_RUN;
      sym_cnt_d     = '0;
      sym_err_cnt_d = '0;
      bit_err_cnt_d = '0;
      ovf_d         = 1'b0;
      udf_d         = 1'b0;
    end else if (state_q == S_RUN && do_pop) begin
      sym_cnt_d     = sat_add(sym_cnt_q, 2'd1);
      sym_err_cnt_d = sat_add(sym_err_cnt_q, {1'b0, mismatch});
      bit_err_cnt_d = sat_add(bit_err_cnt_q, bit_err);
      // FRAME_LEN of zero means free-running: never finish.
      if (FRAME_LEN != 32'd0 && sym_cnt_d == FRAME_LEN) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    // Same-cycle FIFO errors win over a clearing start.
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      state_q       <= S_IDLE;
      det_valid_q   <= 1'b0;
      det_level_q   <= 2'd0;
      sym_err_q     <= 1'b0;
      done_q        <= 1'b0;
      sym_cnt_q     <= '0;
      sym_err_cnt_q <= '0;
      bit_err_cnt_q <= '0;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
    end else begin
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      state_q       <= state_d;
      det_valid_q   <= det_valid_d;
      det_level_q   <= det_level_d;
      sym_err_q     <= sym_err_d;
      done_q        <= done_d;
      sym_cnt_q     <= sym_cnt_d;
      sym_err_cnt_q <= sym_err_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
    end
  end

  assign bus.detectValid    = det_valid_q;
  assign bus.detectLevel    = det_level_q;
  assign bus.symbolError    = sym_err_q;
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = done_q;
  assign bus.symbolCount    = sym_cnt_q;
  assign bus.symbolErrCount = sym_err_cnt_q;
  assign bus.bitErrCount    = bit_err_cnt_q;
  assign bus.fifoOverflow   = ovf_q;
  assign bus.fifoUnderflow  = udf_q;

endmodule

// File: tb/tb_read_level_detector.sv
module tb_read_level_detector;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  read_level_detector_if bif ();

  read_level_detector #(
    .VREF1(16'd2048), .VREF2(16'd4096), .VREF3(16'd6144),
    .FIFO_DEPTH(16), .FRAME_LEN(32'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus, then valids drop; outputs are sampled 1ns after the edge.
  task automatic drive(input logic lv, input logic [1:0] li,
                       input logic vv, input logic [15:0] vi);
    bif.levelValid   = lv;
    bif.levelIn      = li;
    bif.voltageValid = vv;
    bif.voltageIn    = vi;
    step();
    bif.levelValid   = 1'b0;
    bif.voltageValid = 1'b0;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
  endtask

  logic [15:0] v1 [4] = '{16'd100, 16'd2048, 16'd4095, 16'd7000};
  logic [1:0]  l1 [4] = '{2'd0, 2'd1, 2'd1, 2'd3};
  logic        e1 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset            = 1'b1;
    bif.levelValid   = 1'b0;
    bif.levelIn      = 2'd0;
    bif.voltageValid = 1'b0;
    bif.voltageIn    = 16'd0;
    bif.start        = 1'b0;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst_dv",   bif.detectValid, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_cnt",  bif.symbolCount, 0);
    chk("rst_ovf",  bif.fifoOverflow, 0);
    chk("rst_udf",  bif.fifoUnderflow, 0);

    // 1) basic slicing incl. exact-ref boundary; 2) frame end at 4
    pulse_start();
    chk("t1_busy", bif.busy, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 1'b1, v1[i]);
      chk("t1_dv",  bif.detectValid, 1);
      chk("t1_lvl", bif.detectLevel, 32'(l1[i]));
      chk("t1_err", bif.symbolError, 32'(e1[i]));
    end
    chk("t1_cnt",    bif.symbolCount, 4);
    chk("t1_symerr", bif.symbolErrCount, 1);
    chk("t1_biterr", bif.bitErrCount, 1);
    chk("t2_done",   bif.done, 1);
    chk("t2_busy",   bif.busy, 0);
    drive(1'b0, 2'd0, 1'b0, 16'd0);
    chk("t2_done_off", bif.done, 0);
    chk("t2_dv_off",   bif.detectValid, 0);
    drive(1'b1, 2'd3, 1'b0, 16'd0);
    drive(1'b0, 2'd0, 1'b1, 16'd7000);
    chk("t2_dv5",   bif.detectValid, 1);
    chk("t2_hold",  bif.symbolCount, 4);
    chk("t2_done5", bif.done, 0);

    // 3) Gray distance: L0->L3 = 1 bit, L1->L3 = 2 bits
    pulse_start();
    chk("t3_clr",  bif.symbolCount, 0);
    chk("t3_busy", bif.busy, 1);
    drive(1'b1, 2'd0, 1'b0, 16'd0);
    drive(1'b1, 2'd1, 1'b0, 16'd0);
    drive(1'b0, 2'd0, 1'b1, 16'd6500);
    chk("t3_bit_a", bif.bitErrCount, 1);
    drive(1'b0, 2'd0, 1'b1, 16'd6500);
    chk("t3_bit_b",  bif.bitErrCount, 3);
    chk("t3_symerr", bif.symbolErrCount, 2);
    chk("t3_cnt",    bif.symbolCount, 2);

    // 4) fill 16, push+pop while full, then 17th push dropped
    for (int i = 0; i < 16; i++) drive(1'b1, 2'd0, 1'b0, 16'd0);
    drive(1'b1, 2'd2, 1'b1, 16'd100);
    chk("t4_pp_ovf", bif.fifoOverflow, 0);
    chk("t4_pp_err", bif.symbolError, 0);
    drive(1'b1, 2'd3, 1'b0, 16'd0);
    chk("t4_ovf", bif.fifoOverflow, 1);
    for (int i = 0; i < 15; i++) drive(1'b0, 2'd0, 1'b1, 16'd100);
    chk("t4_drain_err", bif.symbolError, 0);
    drive(1'b0, 2'd0, 1'b1, 16'd4096);
    chk("t4_tail_lvl", bif.detectLevel, 2);
    chk("t4_tail_err", bif.symbolError, 0);
    chk("t4_no_udf",   bif.fifoUnderflow, 0);

    // 5) pop while empty with simultaneous push
    pulse_start();
    chk("t5_ovf_clr", bif.fifoOverflow, 0);
    drive(1'b1, 2'd1, 1'b1, 16'd5000);
    chk("t5_dv",  bif.detectValid, 1);
    chk("t5_err", bif.symbolError, 0);
    chk("t5_udf", bif.fifoUnderflow, 1);
    chk("t5_cnt", bif.symbolCount, 0);
    chk("t5_bit", bif.bitErrCount, 0);
    drive(1'b0, 2'd0, 1'b1, 16'd2048);
    chk("t5_head_lvl", bif.detectLevel, 1);
    chk("t5_head_err", bif.symbolError, 0);
    chk("t5_head_cnt", bif.symbolCount, 1);
    chk("t5_udf_hold", bif.fifoUnderflow, 1);

    // 6) reset mid-frame with 3 queued levels
    for (int i = 0; i < 3; i++) drive(1'b1, 2'(i), 1'b0, 16'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_cnt",  bif.symbolCount, 0);
    chk("t6_serr", bif.symbolErrCount, 0);
    chk("t6_berr", bif.bitErrCount, 0);
    chk("t6_busy", bif.busy, 0);
    chk("t6_udf0", bif.fifoUnderflow, 0);
    drive(1'b0, 2'd0, 1'b1, 16'd100);
    chk("t6_udf1", bif.fifoUnderflow, 1);
    chk("t6_err",  bif.symbolError, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
